// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 mouse initialisation controller:
// controller state encoding (also shown on led_state), the PS/2 command
// and response bytes, and the widths of the step index and timeout counter.
// Build option: PS2_SET_RATE_EN adds the set-sample-rate steps, which
// changes NUM_STEPS.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND     = 3'd1,
    ST_WAIT_TX  = 3'd2,
    ST_WAIT_RSP = 3'd3,
    ST_STREAM   = 3'd4,
    ST_ERROR    = 3'd5
  } state_t;

  // Host-to-mouse commands
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;

  // Mouse-to-host responses
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_ID       = 8'h00;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;

  localparam int STEP_W = 3;
  localparam int TO_W   = 27;

`ifdef PS2_SET_RATE_EN
  localparam int NUM_STEPS = 6;
`else
  localparam int NUM_STEPS = 4;
`endif

endpackage

// File: rtl/ps2_init_ctrl_if.sv
// ps2_init_ctrl_if
// Byte-level link between the initialisation controller and the PS/2
// transmitter/receiver.
//   tx_busy  : transmitter is sending (phy -> ctrl)
//   rx_done  : one-cycle strobe, rx_data valid (phy -> ctrl)
//   rx_data  : received byte (phy -> ctrl)
//   tx_start : one-cycle transmit request (ctrl -> phy)
//   tx_data  : byte to send, stable while tx_busy (ctrl -> phy)
// master = controller side, slave = PS/2 phy side.
interface ps2_init_ctrl_if;
  logic       tx_busy;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       tx_start;
  logic [7:0] tx_data;

  modport master (
    input  tx_busy,
    input  rx_done,
    input  rx_data,
    output tx_start,
    output tx_data
  );

  modport slave (
    output tx_busy,
    output rx_done,
    output rx_data,
    input  tx_start,
    input  tx_data
  );
endinterface

// File: rtl/ps2_cmd_rom.sv
// ps2_cmd_rom
// Step table for the mouse initialisation sequence (purely combinational).
//   step_idx : step index
//   tx_byte  : byte to transmit in this step (when has_tx)
//   exp_byte : response that completes this step
//   has_tx   : step transmits a command before waiting
//   is_bat   : step waits for the self-test result (long timeout)
//   is_last  : final step; its response enters streaming
// Build option: PS2_SET_RATE_EN inserts set-rate/rate-value steps before
// the enable command. Out-of-range indices return a harmless no-tx entry.
module ps2_cmd_rom
  import ps2_pkg::*;
#(
  parameter logic [7:0] SAMPLE_RATE = 8'h64
) (
  input  logic [STEP_W-1:0] step_idx,
  output logic [7:0]        tx_byte,
  output logic [7:0]        exp_byte,
  output logic              has_tx,
  output logic              is_bat,
  output logic              is_last
);

  always_comb begin
    tx_byte  = 8'h00;
    exp_byte = RSP_ACK;
    has_tx   = 1'b0;
    is_bat   = 1'b0;
    case (step_idx)
      3'd0: begin
        tx_byte = CMD_RESET;
        has_tx  = 1'b1;
      end
      3'd1: begin
        exp_byte = RSP_BAT_OK;
        is_bat   = 1'b1;
      end
      3'd2: begin
        exp_byte = RSP_ID;
      end
`ifdef PS2_SET_RATE_EN
      3'd3: begin
        tx_byte = CMD_SET_RATE;
        has_tx  = 1'b1;
      end
      3'd4: begin
        tx_byte = SAMPLE_RATE;
        has_tx  = 1'b1;
      end
      3'd5: begin
        tx_byte = CMD_ENABLE;
        has_tx  = 1'b1;
      end
`else
      3'd3: begin
        tx_byte = CMD_ENABLE;
        has_tx  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign is_last = (step_idx == STEP_W'(NUM_STEPS - 1));

`ifndef PS2_SET_RATE_EN
  // The rate command and value only exist in the extended sequence.
  logic [15:0] unused_rate;
  assign unused_rate = {SAMPLE_RATE, CMD_SET_RATE};
`endif

endmodule

// File: rtl/ps2_init_ctrl.sv
// ps2_init_ctrl
// Brings a PS/2 mouse from power-up to streaming mode: reset (FF), wait for
// self-test (AA) and ID (00), then enable reporting (F4). Resend requests
// (FE) repeat the current command; wrong bytes or timeouts restart the
// sequence. Each failure consumes one retry; when none are left the block
// parks in ERROR until start or reset.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start        : one-cycle pulse, restart initialisation from scratch
//   bus          : ps2_init_ctrl_if.master (tx/rx byte link to the phy)
//   stream_en    : mouse streaming, packet assembly enabled
//   init_done    : same as stream_en (status LED)
//   init_err     : retries exhausted
//   led_state    : current state code
// Build option: PS2_SET_RATE_EN adds F3 / SAMPLE_RATE before F4.
module ps2_init_ctrl
  import ps2_pkg::*;
#(
  parameter int         ACK_TO_CYC  = 2_000_000,
  parameter int         BAT_TO_CYC  = 100_000_000,
  parameter int         MAX_RETRY   = 3,
  parameter logic [7:0] SAMPLE_RATE = 8'h64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  ps2_init_ctrl_if.master       bus,
  output logic                  stream_en,
  output logic                  init_done,
  output logic                  init_err,
  output logic [2:0]            led_state
);

  localparam int                RETRY_W   = $clog2(MAX_RETRY + 2);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);
  localparam logic [TO_W-1:0]   ACK_LIM   = TO_W'(ACK_TO_CYC);
  localparam logic [TO_W-1:0]   BAT_LIM   = TO_W'(BAT_TO_CYC);
  localparam logic [TO_W-1:0]   TO_MAX    = '1;

  state_t              state_reg, state_next;
  logic [STEP_W-1:0]   step_reg, step_next, step_inc;
  logic [RETRY_W-1:0]  retry_reg, retry_next;
  logic [TO_W-1:0]     to_cnt_reg, to_cnt_next, to_limit;
  logic [1:0]          wt_cnt_reg, wt_cnt_next;
  logic                tx_start_reg, tx_start_next;
  logic [7:0]          tx_data_reg, tx_data_next;
  logic                fail, resend, to_hold;

  logic [7:0]          cur_tx, cur_exp;
  logic                cur_has_tx, cur_is_bat, cur_is_last;
  logic                nxt_has_tx;
  logic [7:0]          unused_nxt_tx, unused_nxt_exp;
  logic                unused_nxt_bat, unused_nxt_last;

  assign step_inc = step_reg + STEP_W'(1);

  // Current step drives the FSM; the following step is looked up so an
  // advance can go straight to SEND or stay in WAIT_RSP.
  ps2_cmd_rom #(.SAMPLE_RATE(SAMPLE_RATE)) u_rom_cur (
    .step_idx (step_reg),
    .tx_byte  (cur_tx),
    .exp_byte (cur_exp),
    .has_tx   (cur_has_tx),
    .is_bat   (cur_is_bat),
    .is_last  (cur_is_last)
  );

  ps2_cmd_rom #(.SAMPLE_RATE(SAMPLE_RATE)) u_rom_nxt (
    .step_idx (step_inc),
    .tx_byte  (unused_nxt_tx),
    .exp_byte (unused_nxt_exp),
    .has_tx   (nxt_has_tx),
    .is_bat   (unused_nxt_bat),
    .is_last  (unused_nxt_last)
  );

  assign to_limit = cur_is_bat ? BAT_LIM : ACK_LIM;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      step_reg     <= '0;
      retry_reg    <= '0;
      to_cnt_reg   <= '0;
      wt_cnt_reg   <= '0;
      tx_start_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
    end else begin
      state_reg    <= state_next;
      step_reg     <= step_next;
      retry_reg    <= retry_next;
      to_cnt_reg   <= to_cnt_next;
      wt_cnt_reg   <= wt_cnt_next;
      tx_start_reg <= tx_start_next;
      tx_data_reg  <= tx_data_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    step_next     = step_reg;
    retry_next    = retry_reg;
    tx_start_next = 1'b0;
    tx_data_next  = tx_data_reg;
    to_hold       = 1'b0;
    fail          = 1'b0;
    resend        = 1'b0;

    case (state_reg)
      ST_IDLE: state_next = ST_SEND;

      ST_SEND: begin
        if (!bus.tx_busy) begin
          tx_start_next = 1'b1;
          tx_data_next  = cur_tx;
          state_next    = ST_WAIT_TX;
        end
      end

      // wt_cnt guarantees the phy has had time to raise tx_busy before
      // its low level is taken as "byte sent".
      ST_WAIT_TX: begin
        if (wt_cnt_reg == 2'd2 && !bus.tx_busy) begin
          state_next = ST_WAIT_RSP;
        end
      end

      ST_WAIT_RSP: begin
        if (bus.rx_done) begin
          if (bus.rx_data == cur_exp) begin
            if (cur_is_last) begin
              state_next = ST_STREAM;
            end else begin
              step_next  = step_inc;
              state_next = nxt_has_tx ? ST_SEND : ST_WAIT_RSP;
            end
          end else if (bus.rx_data == RSP_RESEND && cur_has_tx) begin
            fail   = 1'b1;
            resend = 1'b1;
          end else begin
            fail = 1'b1;
          end
        end else if (to_cnt_reg >= to_limit) begin
          fail = 1'b1;
        end else begin
          to_hold = 1'b1;
        end
      end

      ST_STREAM, ST_ERROR: ;

      default: state_next = ST_IDLE;
    endcase

    if (fail) begin
      if (retry_reg == RETRY_LIM) begin
        state_next = ST_ERROR;
      end else begin
        retry_next = retry_reg + RETRY_W'(1);
        state_next = ST_SEND;
        if (!resend) begin
          step_next = '0;
        end
      end
    end

    // start overrides whatever the state logic decided this cycle
    if (start) begin
      state_next    = ST_SEND;
      step_next     = '0;
      retry_next    = '0;
      tx_start_next = 1'b0;
      tx_data_next  = tx_data_reg;
      to_hold       = 1'b0;
    end
  end

  // Response timer: cleared on every entry into WAIT_RSP, saturating.
  always_comb begin
    to_cnt_next = '0;
    if (to_hold) begin
      to_cnt_next = (to_cnt_reg == TO_MAX) ? to_cnt_reg : to_cnt_reg + TO_W'(1);
    end
  end

  always_comb begin
    wt_cnt_next = 2'd0;
    if (state_reg == ST_WAIT_TX && state_next == ST_WAIT_TX) begin
      wt_cnt_next = (wt_cnt_reg == 2'd2) ? wt_cnt_reg : wt_cnt_reg + 2'd1;
    end
  end

  assign bus.tx_start = tx_start_reg;
  assign bus.tx_data  = tx_data_reg;
  assign stream_en    = (state_reg == ST_STREAM);
  assign init_done    = (state_reg == ST_STREAM);
  assign init_err     = (state_reg == ST_ERROR);
  assign led_state    = state_reg;

endmodule

// File: tb/tb_ps2_init_ctrl.sv
// tb_ps2_init_ctrl
// Bench for ps2_init_ctrl: a phy model records every transmitted byte and
// raises tx_busy; a mouse driver answers each response wait from a script
// (-1 = stay silent). Expected results come from a step-level model of the
// initialisation rules, from a table of hand-derived vectors, and from a
// few hand-written sequences (timeouts, start/rx collisions, streaming).
module tb_ps2_init_ctrl;

  localparam int ACK  = 100;
  localparam int BAT  = 300;
  localparam int MAXR = 3;
  localparam int BUDGET = 6000;
`ifdef PS2_SET_RATE_EN
  localparam int NS = 6;
`else
  localparam int NS = 4;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stream_en, init_done, init_err;
  logic [2:0] led_state;

  ps2_init_ctrl_if bus ();

  ps2_init_ctrl #(
    .ACK_TO_CYC  (ACK),
    .BAT_TO_CYC  (BAT),
    .MAX_RETRY   (MAXR),
    .SAMPLE_RATE (8'h28)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .stream_en (stream_en),
    .init_done (init_done),
    .init_err  (init_err),
    .led_state (led_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int txlog[$];

  // step description of the mouse protocol
  int s_tx[NS];
  int s_rsp[NS];
  bit s_has[NS];

  // step-level reference model
  int m_step, m_retry, m_fin;
  int m_tx[$];

  typedef struct {
    int          n_act;
    logic [95:0] acts;
    int          n_tx;
    logic [95:0] txs;
    int          fin;
  } vec_t;
  vec_t tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    total++;
    if (got < lo || got > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", name, got, lo, hi);
    end
  endtask

  function automatic logic [95:0] lj(input int n, input logic [95:0] v);
    return v << (8 * (12 - n));
  endfunction

  // phy: log each tx_start, stay busy for a while afterwards
  initial begin : phy
    int busy_left;
    busy_left   = 0;
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) bus.tx_busy = 1'b0;
      end
      if (bus.tx_start) begin
        txlog.push_back(int'(bus.tx_data));
        bus.tx_busy = 1'b1;
        busy_left   = 8;
      end
    end
  end

  task automatic model_reset();
    m_step = 0;
    m_retry = 0;
    m_fin = 0;
    m_tx.delete();
    m_tx.push_back(s_tx[0]);
  endtask

  task automatic model_apply(input int a);
    if (m_fin == 0) begin
      if (a >= 0 && a == s_rsp[m_step]) begin
        if (m_step == NS - 1) m_fin = 4;
        else begin
          m_step++;
          if (s_has[m_step]) m_tx.push_back(s_tx[m_step]);
        end
      end else if (m_retry == MAXR) begin
        m_fin = 5;
      end else begin
        m_retry++;
        if (!(a == 8'hFE && s_has[m_step])) m_step = 0;
        m_tx.push_back(s_tx[m_step]);
      end
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    start = 1'b0;
    bus.rx_done = 1'b0;
    tick();
    tick();
    txlog.delete();
    reset = 1'b0;
  endtask

  task automatic wait_state(input int s, input string name);
    int n = 0;
    while (int'(led_state) != s && n < 2000) begin
      tick();
      n++;
    end
    check(name, int'(led_state), s);
  endtask

  // answer each response wait from the script until STREAM or ERROR
  task automatic drive_script(input int acts[$]);
    int idx = 0;
    int t0  = cyc;
    int a;
    bit done = 0;
    while (!done) begin
      if (led_state == 3'd4 || led_state == 3'd5) begin
        done = 1;
      end else if (cyc - t0 > BUDGET) begin
        total++;
        bad++;
        $display("FAIL script_budget: state %0d after %0d cycles", led_state, cyc - t0);
        done = 1;
      end else if (led_state == 3'd3 && idx < acts.size()) begin
        a = acts[idx];
        idx++;
        if (a < 0) begin
          while (led_state == 3'd3 && cyc - t0 <= BUDGET) tick();
        end else begin
          repeat ($urandom_range(1, 4)) tick();
          bus.rx_data = a[7:0];
          bus.rx_done = 1'b1;
          tick();
          bus.rx_done = 1'b0;
          bus.rx_data = 8'($urandom);
        end
      end else begin
        tick();
      end
    end
  endtask

  task automatic verify(input string tag, input int acts_n, input int exp_tx[$], input int exp_fin);
    int n;
    check({tag, "_ntx"}, txlog.size(), exp_tx.size());
    n = (txlog.size() < exp_tx.size()) ? txlog.size() : exp_tx.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_tx%0d", tag, i), txlog[i], exp_tx[i]);
    check({tag, "_state"}, int'(led_state), exp_fin);
    check({tag, "_err"}, int'(init_err), (exp_fin == 5) ? 1 : 0);
    check({tag, "_stream"}, int'(stream_en), (exp_fin == 4) ? 1 : 0);
    check({tag, "_done"}, int'(init_done), (exp_fin == 4) ? 1 : 0);
    $display("%s: replies=%0d tx_bytes=%0d state=%0d", tag, acts_n, txlog.size(), led_state);
  endtask

  task automatic run_case(input string tag, input int acts[$], input int exp_tx[$], input int exp_fin);
    reset_dut();
    drive_script(acts);
    verify(tag, acts.size(), exp_tx, exp_fin);
  endtask

  initial begin : main
    int acts[$];
    int exp_tx[$];
    int base_acts[$];
    int base_tx[$];
    int n;
    int a;
    int kind;

    reset = 1'b1;
    start = 1'b0;
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;

`ifdef PS2_SET_RATE_EN
    s_tx  = '{8'hFF, 0, 0, 8'hF3, 8'h28, 8'hF4};
    s_rsp = '{8'hFA, 8'hAA, 8'h00, 8'hFA, 8'hFA, 8'hFA};
    s_has = '{1, 0, 0, 1, 1, 1};
    base_acts = '{8'hFA, 8'hAA, 8'h00, 8'hFA, 8'hFA, 8'hFA};
    base_tx   = '{8'hFF, 8'hF3, 8'h28, 8'hF4};
    tbl[0] = '{6, lj(6, {8'hFA,8'hAA,8'h00,8'hFA,8'hFA,8'hFA}), 4, lj(4, {8'hFF,8'hF3,8'h28,8'hF4}), 4};
    tbl[1] = '{7, lj(7, {8'hFE,8'hFA,8'hAA,8'h00,8'hFA,8'hFA,8'hFA}), 5, lj(5, {8'hFF,8'hFF,8'hF3,8'h28,8'hF4}), 4};
    tbl[3] = '{8, lj(8, {8'hFA,8'h55,8'hFA,8'hAA,8'h00,8'hFA,8'hFA,8'hFA}), 5, lj(5, {8'hFF,8'hFF,8'hF3,8'h28,8'hF4}), 4};
    tbl[4] = '{9, lj(9, {8'hFA,8'hAA,8'hFE,8'hFA,8'hAA,8'h00,8'hFA,8'hFA,8'hFA}), 5, lj(5, {8'hFF,8'hFF,8'hF3,8'h28,8'hF4}), 4};
`else
    s_tx  = '{8'hFF, 0, 0, 8'hF4};
    s_rsp = '{8'hFA, 8'hAA, 8'h00, 8'hFA};
    s_has = '{1, 0, 0, 1};
    base_acts = '{8'hFA, 8'hAA, 8'h00, 8'hFA};
    base_tx   = '{8'hFF, 8'hF4};
    tbl[0] = '{4, lj(4, {8'hFA,8'hAA,8'h00,8'hFA}), 2, lj(2, {8'hFF,8'hF4}), 4};
    tbl[1] = '{5, lj(5, {8'hFE,8'hFA,8'hAA,8'h00,8'hFA}), 3, lj(3, {8'hFF,8'hFF,8'hF4}), 4};
    tbl[3] = '{6, lj(6, {8'hFA,8'h55,8'hFA,8'hAA,8'h00,8'hFA}), 3, lj(3, {8'hFF,8'hFF,8'hF4}), 4};
    tbl[4] = '{7, lj(7, {8'hFA,8'hAA,8'hFE,8'hFA,8'hAA,8'h00,8'hFA}), 3, lj(3, {8'hFF,8'hFF,8'hF4}), 4};
`endif
    // silent mouse and four resend requests both exhaust the retries
    tbl[2] = '{0, 96'h0, 4, lj(4, {8'hFF,8'hFF,8'hFF,8'hFF}), 5};
    tbl[5] = '{4, lj(4, {8'hFE,8'hFE,8'hFE,8'hFE}), 4, lj(4, {8'hFF,8'hFF,8'hFF,8'hFF}), 5};

    // reset values
    tick();
    tick();
    check("rst_led", int'(led_state), 0);
    check("rst_tx_start", int'(bus.tx_start), 0);
    check("rst_tx_data", int'(bus.tx_data), 0);
    check("rst_stream", int'(stream_en), 0);
    check("rst_done", int'(init_done), 0);
    check("rst_err", int'(init_err), 0);
    reset = 1'b0;
    tick();
    check("auto_init_send", int'(led_state), 1);

    // table vectors
    for (int v = 0; v < 6; v++) begin
      acts.delete();
      exp_tx.delete();
      for (int i = 0; i < tbl[v].n_act; i++) acts.push_back(int'(tbl[v].acts[95 - 8*i -: 8]));
      for (int i = 0; i < tbl[v].n_tx; i++) exp_tx.push_back(int'(tbl[v].txs[95 - 8*i -: 8]));
      run_case($sformatf("vec%0d", v), acts, exp_tx, tbl[v].fin);
      if (v == 0) begin
        // streaming: received bytes are ignored, nothing is sent
        n = txlog.size();
        bus.rx_data = 8'hFE;
        bus.rx_done = 1'b1;
        tick();
        bus.rx_done = 1'b0;
        repeat (20) tick();
        check("stream_hold", int'(led_state), 4);
        check("stream_no_tx", txlog.size(), n);
      end
      if (v == 2) begin
        // start leaves ERROR and clears the error flag
        start = 1'b1;
        tick();
        start = 1'b0;
        check("err_start_led", int'(led_state), 1);
        check("err_start_flag", int'(init_err), 0);
      end
    end

    // ACK timeout length (step 0)
    reset_dut();
    wait_state(3, "ack_to_enter");
    n = 0;
    while (led_state == 3'd3 && n < 1000) begin
      tick();
      n++;
    end
    check_range("ack_to_len", n, ACK - 1, ACK + 3);
    check("ack_to_resend", int'(led_state), 1);

    // self-test timeout length (step 1)
    reset_dut();
    wait_state(3, "bat_to_enter");
    bus.rx_data = 8'hFA;
    bus.rx_done = 1'b1;
    tick();
    bus.rx_done = 1'b0;
    n = 0;
    while (led_state == 3'd3 && n < 1000) begin
      tick();
      n++;
    end
    check_range("bat_to_len", n, BAT - 1, BAT + 3);

    // rx_done while the command is still going out is ignored
    reset_dut();
    wait_state(2, "wtx_enter");
    bus.rx_data = 8'hFA;
    bus.rx_done = 1'b1;
    tick();
    bus.rx_done = 1'b0;
    drive_script(base_acts);
    verify("rx_in_wait_tx", base_acts.size(), base_tx, 4);

    // start beats a simultaneous ACK in WAIT_RSP
    reset_dut();
    wait_state(3, "start_enter");
    tick();
    start = 1'b1;
    bus.rx_data = 8'hFA;
    bus.rx_done = 1'b1;
    tick();
    start = 1'b0;
    bus.rx_done = 1'b0;
    check("start_prio_led", int'(led_state), 1);
    drive_script(base_acts);
    exp_tx = base_tx;
    exp_tx.push_front(8'hFF);
    verify("start_prio", base_acts.size(), exp_tx, 4);

    // randomised replies against the step-level model
    for (int r = 0; r < 12; r++) begin
      acts.delete();
      model_reset();
      for (int k = 0; k < 14 && m_fin == 0; k++) begin
        kind = $urandom_range(0, 9);
        if (kind == 6) a = 8'hFE;
        else if (kind == 7) a = 8'h55;
        else if (kind == 8) a = -1;
        else a = s_rsp[m_step];
        acts.push_back(a);
        model_apply(a);
      end
      while (m_fin == 0) model_apply(-1);
      run_case($sformatf("rnd%0d", r), acts, m_tx, m_fin);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_init_ctrl.md
PS2_INIT_CTRL -- requirements
Module: ps2_init_ctrl

Interface
REQ-001 Parameter ACK_TO_CYC, default 2_000_000, is the ACK/ID wait timeout in clk cycles (20 ms @100 MHz).
REQ-002 Parameter BAT_TO_CYC, default 100_000_000, is the self-test (0xAA) wait timeout in clk cycles.
REQ-003 Parameter MAX_RETRY, default 3, is the number of full-sequence restarts allowed before error.
REQ-004 Parameter SAMPLE_RATE, default 8'h64, is the sample-rate byte (used only with PS2_SET_RATE_EN).
REQ-005 Port clk, input, 1: system clock.
REQ-006 Port reset, input, 1: one clock; reset is synchronous and active-high.
REQ-007 Port start, input, 1: single-cycle pulse (debounced button) that restarts initialisation.
REQ-008 Port tx_busy, input, 1: high while the PS/2 transmitter is sending.
REQ-009 Port rx_done, input, 1: single-cycle pulse, rx_data is valid.
REQ-010 Port rx_data, input, 8: received byte.
REQ-011 Port tx_start, output, 1: single-cycle transmit request.
REQ-012 Port tx_data, output, 8: byte to transmit, held stable while tx_busy is high.
REQ-013 Port stream_en, output, 1: high when the mouse is streaming and packet assembly is enabled.
REQ-014 Port init_done, output, 1: same as stream_en, kept as a separate status LED.
REQ-015 Port init_err, output, 1: retries are exhausted.
REQ-016 Port led_state, output, 3: encoded FSM state.

Function
REQ-017 The FSM SHALL have states IDLE=0, SEND=1, WAIT_TX=2, WAIT_RSP=3, STREAM=4 and ERROR=5; led_state SHALL equal the state code.
REQ-018 The command sequence SHALL be step 0 send 0xFF/expect 0xFA, step 1 expect 0xAA (no send), step 2 expect 0x00 (no send), then final step send 0xF4/expect 0xFA.
REQ-019 In SEND, the block SHALL wait for tx_busy=0, then pulse tx_start for exactly 1 cycle with tx_data=step byte, and go to WAIT_TX.
REQ-020 WAIT_TX SHALL go to WAIT_RSP on the first cycle that tx_busy is 0, at least 2 cycles after tx_start.
REQ-021 On entering WAIT_RSP, the timeout counter SHALL clear; the limit is BAT_TO_CYC for step 1 and ACK_TO_CYC otherwise.
REQ-022 If rx_done occurs with the expected byte, the step SHALL advance; the next step is SEND if it transmits, else WAIT_RSP (counter cleared).
REQ-023 If rx_done occurs with 0xFE after a transmitted byte, the same byte SHALL be resent (go to SEND); each resend SHALL count as one retry.
REQ-024 If rx_done occurs with any other byte, or the counter reaches its limit, the retry count SHALL increment and the step SHALL return to 0 (SEND).
REQ-025 When the retry count would exceed MAX_RETRY, the block SHALL go to ERROR with init_err=1 and hold there until start or reset.
REQ-026 After the final-step ACK, the block SHALL go to STREAM; stream_en and init_done SHALL be 1 from the next cycle.
REQ-027 In STREAM, rx bytes SHALL be ignored and the block SHALL not transmit.
REQ-028 rx_done pulses in SEND or WAIT_TX SHALL be ignored.
REQ-029 A start pulse in any state SHALL, on the next cycle, clear retries, init_err, stream_en and step, then enter SEND; start SHALL take priority over a simultaneous rx_done or timeout.
REQ-030 The timeout counter SHALL be 27 bits wide and saturate, never wrap.

Reset
REQ-031 On reset, state SHALL be IDLE, step=0, retries=0, tx_start=0, tx_data=8'h00, stream_en=0, init_done=0, init_err=0 and led_state=0.
REQ-032 IDLE SHALL move to SEND on the first cycle after reset deasserts (auto-init); reset mid-transfer SHALL abort silently.

Configuration
REQ-033 With macro PS2_SET_RATE_EN defined, the steps send 0xF3/expect 0xFA and send SAMPLE_RATE/expect 0xFA SHALL be inserted between the ID step and the 0xF4 step.
REQ-034 Without PS2_SET_RATE_EN, the sequence SHALL be exactly that of REQ-018 and SAMPLE_RATE SHALL be unused.

Structure
REQ-035 Package ps2_pkg SHALL hold the command/response constants (0xFF, 0xFA, 0xAA, 0x00, 0xF3, 0xF4, 0xFE) and the state encoding.
REQ-036 The step table SHALL be a sub-module ps2_cmd_rom: input step index; outputs tx byte, expected byte, has_tx, is_bat and is_last.

Verification
REQ-037 Release reset, model replies FA, AA, 00, FA -> tx bytes FF then F4, stream_en=1, led_state=4.
REQ-038 Reply FE to 0xFF -> 0xFF resent once, and the sequence then completes.
REQ-039 No reply, with ACK_TO_CYC=100 and MAX_RETRY=3 -> 0xFF sent 4 times, then init_err=1 and led_state=5.
REQ-040 Reply FA, then 0x55 instead of AA -> restart from 0xFF with retry count 1.
REQ-041 start pulse during WAIT_RSP, coincident with rx_done=FA -> FA ignored and 0xFF re-sent.
REQ-042 With PS2_SET_RATE_EN and SAMPLE_RATE=8'h28 -> tx bytes FF, F3, 28, F4 in order, then STREAM.
